// File: rtl/lsu32.sv
`default_nettype none
// ============================================================================
// Module   : lsu32
// Purpose  : Load/store unit sitting after the execute ALU. Accepts one memory
//            op at a time, issues a single word-aligned request on a
//            valid/ready data-memory port, then aligns and sign/zero-extends
//            load data and returns it to writeback. Illegal funct3 codes and
//            misaligned addresses raise a one-cycle exception pulse instead
//            of touching memory.
// Ports    : clk_i/rst_i            clock, synchronous active-high reset
//            valid_i/ready_o        op handshake from execute
//            load_i/store_i/funct3_i/addr_i/wdata_i/rd_i   op description
//            mem_*                  data-memory request / response port
//            wb_*                   writeback completion (one-cycle pulse)
//            exc_o                  misaligned/illegal pulse
// Revision : 1.0 - initial release
// ============================================================================
module lsu32 #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            load_i,
  input  logic            store_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      rd_i,
  output logic            mem_valid_o,
  input  logic            mem_ready_i,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [3:0]      mem_wstrb_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            wb_valid_o,
  output logic            wb_we_o,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            exc_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              is_load_q, is_load_d;
  logic [4:0]        rd_q, rd_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;

  logic              accept;
  logic              legal;
  logic              misaligned;
  logic [3:0]        fmt_wstrb;
  logic [XLEN-1:0]   fmt_wdata;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [XLEN-1:0]   ld_ext;

  // Op decode and store-lane formatting on the incoming request
  always_comb begin
    accept     = valid_i & (state_q == ST_IDLE) & (load_i | store_i);

    legal      = 1'b0;
    if (load_i) begin
      case (funct3_i)
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: legal = 1'b1;
        default:                      legal = 1'b0;
      endcase
    end else begin
      case (funct3_i)
        3'd0, 3'd1, 3'd2: legal = 1'b1;
        default:          legal = 1'b0;
      endcase
    end

    // funct3[1:0] encodes access size for both loads and stores
    misaligned = 1'b0;
    case (funct3_i[1:0])
      2'b01:   misaligned = addr_i[0];
      2'b10:   misaligned = |addr_i[1:0];
      default: misaligned = 1'b0;
    endcase

    fmt_wstrb = 4'b0000;
    fmt_wdata = '0;
    if (store_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          fmt_wstrb = 4'b0001 << addr_i[1:0];
          fmt_wdata = {4{wdata_i[7:0]}};
        end
        2'b01: begin
          fmt_wstrb = 4'b0011 << addr_i[1:0];
          fmt_wdata = {2{wdata_i[15:0]}};
        end
        default: begin
          fmt_wstrb = 4'b1111;
          fmt_wdata = wdata_i;
        end
      endcase
    end
  end

  // Load data alignment and extension, driven by the registered address/code
  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = mem_rdata_i[7:0];
      2'b01:   ld_byte = mem_rdata_i[15:8];
      2'b10:   ld_byte = mem_rdata_i[23:16];
      default: ld_byte = mem_rdata_i[31:24];
    endcase
    ld_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

    case (funct3_q)
      3'd0:    ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'd1:    ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'd4:    ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
      3'd5:    ld_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_ext = mem_rdata_i;
    endcase
  end

  // Next-state and register update
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    funct3_d  = funct3_q;
    is_load_d = is_load_q;
    rd_d      = rd_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    wb_data_d = wb_data_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d    = addr_i;
          funct3_d  = funct3_i;
          is_load_d = load_i;
          rd_d      = rd_i;
          wstrb_d   = fmt_wstrb;
          wdata_d   = fmt_wdata;
          state_d   = (legal && !misaligned) ? ST_REQ : ST_FAULT;
        end
      end
      ST_REQ: begin
        if (mem_ready_i) begin
          state_d = is_load_q ? ST_WAIT : ST_DONE;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid_i) begin
          wb_data_d = ld_ext;
          state_d   = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      funct3_q  <= 3'd0;
      is_load_q <= 1'b0;
      rd_q      <= 5'd0;
      wstrb_q   <= 4'b0000;
      wdata_q   <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      funct3_q  <= funct3_d;
      is_load_q <= is_load_d;
      rd_q      <= rd_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Outputs are decoded from registered state only; nothing combinational
  // passes from inputs to outputs.
  assign ready_o     = (state_q == ST_IDLE);
  assign mem_valid_o = (state_q == ST_REQ);
  assign mem_we_o    = (state_q == ST_REQ) & ~is_load_q;
  assign mem_addr_o  = {addr_q[XLEN-1:2], 2'b00};
  assign mem_wstrb_o = wstrb_q;
  assign mem_wdata_o = wdata_q;
  assign wb_valid_o  = (state_q == ST_DONE);
  assign wb_we_o     = (state_q == ST_DONE) & is_load_q & (rd_q != 5'd0);
  assign wb_rd_o     = rd_q;
  assign wb_data_o   = wb_data_q;
  assign exc_o       = (state_q == ST_FAULT);

endmodule
`default_nettype wire
